// File: rtl/boot_stream_loader.sv
// -----------------------------------------------------------------------------
// boot_stream_loader
//
// Receiving end of the tile boot stream. Paired instruction/data beats from the
// external boot port are written into the selected tile's imem/dmem one cycle
// after they are accepted. A per-tile done flag is kept so each tile is released
// from reset only once its whole image has landed.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, a running sum of in_idata + in_ddata is kept per load. A tile
//   whose sum differs from exp_sum at the end of the load is not marked done,
//   and err pulses. When undefined, checksum is tied to 0 and exp_sum is ignored.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   start, sel            one-cycle load request for tile sel
//   in_valid, in_ready    stream handshake; a beat moves when both are high
//   in_idata, in_ddata    instruction / data word of the beat
//   wr_tile               tile targeted by the write ports
//   imem_we/addr/wdata    instruction memory write port
//   dmem_we/addr/wdata    data memory write port
//   busy                  a load is in progress
//   tile_done             per-tile booted flags (reset release)
//   all_done              every tile_done bit set (registered)
//   err                   one-cycle error pulse
//   exp_sum, checksum     expected / running checksum (optional feature)
// -----------------------------------------------------------------------------
module boot_stream_loader #(
   parameter int NUM_TILES  = 90,
   parameter int SEL_WIDTH  = 7,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 16384
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [SEL_WIDTH-1:0]  sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_idata,
   input  logic [DATA_WIDTH-1:0] in_ddata,
   output logic [SEL_WIDTH-1:0]  wr_tile,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic                  busy,
   output logic [NUM_TILES-1:0]  tile_done,
   output logic                  all_done,
   output logic                  err,
   input  logic [DATA_WIDTH-1:0] exp_sum,
   output logic [DATA_WIDTH-1:0] checksum
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // One extra counter bit so a full 2^ADDR_WIDTH image never aliases to 0.
   localparam logic [ADDR_WIDTH:0] LAST_BEAT  = (ADDR_WIDTH+1)'(WORDS - 1);
   localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [SEL_WIDTH:0]  TILE_LIMIT = (SEL_WIDTH+1)'(NUM_TILES);

   state_t              state;
   logic [ADDR_WIDTH:0] cnt;
   logic                accept;
   logic                sel_ok;
   logic                sum_ok;

   assign accept = in_valid & in_ready;
   assign sel_ok = ({1'b0, sel} < TILE_LIMIT);

`ifdef BOOT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q;

   // Cleared only by a valid start so the final sum stays readable afterwards.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sum_q <= '0;
      end else if (state == IDLE && start && sel_ok) begin
         sum_q <= '0;
      end else if (state == LOAD && accept) begin
         sum_q <= sum_q + in_idata + in_ddata;
      end
   end

   assign sum_ok   = (sum_q == exp_sum);
   assign checksum = sum_q;
`else
   logic unused_exp_sum;

   assign unused_exp_sum = ^exp_sum;
   assign sum_ok         = 1'b1;
   assign checksum       = '0;
`endif

   // NOTE: every register here is updated with <= so all reads within a clock
   // see the pre-edge values; the reset is sampled on the clock edge only.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         in_ready   <= 1'b0;
         wr_tile    <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         busy       <= 1'b0;
         tile_done  <= '0;
         all_done   <= 1'b0;
         err        <= 1'b0;
      end else begin
         // Strobes and err are single-cycle; they only rise where set below.
         imem_we  <= 1'b0;
         dmem_we  <= 1'b0;
         err      <= 1'b0;
         all_done <= &tile_done;

         case (state)
            IDLE: begin
               in_ready <= 1'b0;
               busy     <= 1'b0;
               if (start) begin
                  if (sel_ok) begin
                     wr_tile        <= sel;
                     cnt            <= '0;
                     tile_done[sel] <= 1'b0;
                     busy           <= 1'b1;
                     state          <= LOAD;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            LOAD: begin
               // in_ready opens one cycle after entering LOAD and stays up
               // until the final beat has been taken.
               in_ready <= 1'b1;
               if (start) begin
                  err <= 1'b1;
               end
               if (accept) begin
                  imem_we    <= 1'b1;
                  dmem_we    <= 1'b1;
                  imem_addr  <= cnt[ADDR_WIDTH-1:0];
                  dmem_addr  <= cnt[ADDR_WIDTH-1:0];
                  imem_wdata <= in_idata;
                  dmem_wdata <= in_ddata;
                  cnt        <= cnt + CNT_ONE;
                  if (cnt == LAST_BEAT) begin
                     in_ready <= 1'b0;
                     state    <= FLUSH;
                  end
               end
            end

            FLUSH: begin
               // The last write is on the ports this cycle; it completes on
               // the same edge that marks the tile done.
               in_ready <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
               if (sum_ok) begin
                  tile_done[wr_tile] <= 1'b1;
               end
               if (start || !sum_ok) begin
                  err <= 1'b1;
               end
            end

            default: begin
               in_ready <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_stream_loader
//
// Directed bench for boot_stream_loader with WORDS=4 and 90 tiles. Inputs are
// driven on the falling edge; a monitor samples the DUT 2 ns after each rising
// edge, records every write and checks each strobe against the handshake seen
// just before that edge. Define BOOT_CHECKSUM_EN to include the checksum case.
// -----------------------------------------------------------------------------
module tb_boot_stream_loader;

   localparam int NT = 90;
   localparam int SW = 7;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [SW-1:0] sel;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_idata;
   logic [DW-1:0] in_ddata;
   logic [SW-1:0] wr_tile;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          busy;
   logic [NT-1:0] tile_done;
   logic          all_done;
   logic          err;
   logic [DW-1:0] exp_sum;
   logic [DW-1:0] checksum;

   boot_stream_loader #(
      .NUM_TILES (NT),
      .SEL_WIDTH (SW),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .WORDS     (NW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idata  (in_idata),
      .in_ddata  (in_ddata),
      .wr_tile   (wr_tile),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .dmem_we   (dmem_we),
      .dmem_addr (dmem_addr),
      .dmem_wdata(dmem_wdata),
      .busy      (busy),
      .tile_done (tile_done),
      .all_done  (all_done),
      .err       (err),
      .exp_sum   (exp_sum),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] idata;
      logic [DW-1:0] ddata;
      logic [SW-1:0] tile;
      int            cyc;
   } wr_t;

   wr_t wq[$];
   int  n_checks   = 0;
   int  n_pass     = 0;
   int  cyc_g      = 0;
   int  busy_cyc   = 0;
   int  err_cnt    = 0;
   int  strobe_bad = 0;
   int  data_bad   = 0;

   logic          mon_we;
   logic [DW-1:0] mon_id;
   logic [DW-1:0] mon_dd;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // A write must appear exactly when a beat was taken at the preceding edge.
   always @(posedge clk) begin
      mon_we = resetn && in_valid && in_ready;
      mon_id = in_idata;
      mon_dd = in_ddata;
      #2;
      cyc_g++;
      if (imem_we !== mon_we || dmem_we !== mon_we) strobe_bad++;
      if (imem_we === 1'b1) begin
         if (imem_wdata !== mon_id || dmem_wdata !== mon_dd || dmem_addr !== imem_addr) data_bad++;
         wq.push_back('{addr: imem_addr, idata: imem_wdata, ddata: dmem_wdata, tile: wr_tile, cyc: cyc_g});
      end
      if (busy === 1'b1) busy_cyc++;
      if (err === 1'b1) err_cnt++;
   end

   // Runs one load from a falling edge. vpat gives in_valid per cycle (repeating
   // every 16); beat k carries ib+k / db+k. inject_at pulses start with sel=2 in
   // that loop cycle, reset_at pulls resetn low in that loop cycle (-1 = never).
   task automatic run_load(input logic [SW-1:0] t, input logic [DW-1:0] ib, input logic [DW-1:0] db,
                           input logic [15:0] vpat, input int inject_at, input int reset_at,
                           output logic [NT-1:0] mid_td, output logic mid_ad);
      int cyc;
      int acc;
      wq.delete();
      busy_cyc = 0;
      err_cnt  = 0;
      mid_td   = '0;
      mid_ad   = 1'b0;
      // NOTE: stimulus uses blocking assignments on the falling edge, well
      // clear of the edge the DUT samples on.
      start = 1'b1;
      sel   = t;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      acc   = 0;
      while (busy && cyc < 60) begin
         if (cyc == reset_at) resetn = 1'b0;
         start    = (cyc == inject_at);
         sel      = (cyc == inject_at) ? 7'd2 : t;
         in_valid = vpat[cyc % 16];
         in_idata = ib + acc;
         in_ddata = db + acc;
         if (in_valid && in_ready) acc++;
         if (cyc == 2) begin
            mid_td = tile_done;
            mid_ad = all_done;
         end
         @(negedge clk);
         cyc++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      check($sformatf("load_t%0d_ends", t), 128'(cyc < 60), 128'(1));
      if (!resetn) begin
         @(negedge clk);
         resetn = 1'b1;
      end
   endtask

   logic [NT-1:0] m_td;
   logic          m_ad;
   logic [15:0]   gap_pat;

   initial begin
      resetn   = 1'b0;
      start    = 1'b0;
      sel      = '0;
      in_valid = 1'b0;
      in_idata = '0;
      in_ddata = '0;
      exp_sum  = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy",      128'(busy),      128'(0));
      check("rst_in_ready",  128'(in_ready),  128'(0));
      check("rst_imem_we",   128'(imem_we),   128'(0));
      check("rst_dmem_we",   128'(dmem_we),   128'(0));
      check("rst_tile_done", 128'(tile_done), 128'(0));
      check("rst_all_done",  128'(all_done),  128'(0));
      check("rst_err",       128'(err),       128'(0));
      check("rst_wr_tile",   128'(wr_tile),   128'(0));
      check("rst_checksum",  128'(checksum),  128'(0));
      resetn = 1'b1;
      @(negedge clk);

      // 1: plain load of tile 3, in_valid held high
      run_load(7'd3, 32'h10, 32'h20, 16'hFFFF, -1, -1, m_td, m_ad);
      check("t1_nwrites", 128'(wq.size()), 128'(4));
      for (int k = 0; k < 4 && k < wq.size(); k++) begin
         check($sformatf("t1_addr%0d", k),  128'(wq[k].addr),  128'(k));
         check($sformatf("t1_idata%0d", k), 128'(wq[k].idata), 128'(32'h10 + k));
         check($sformatf("t1_ddata%0d", k), 128'(wq[k].ddata), 128'(32'h20 + k));
         check($sformatf("t1_tile%0d", k),  128'(wq[k].tile),  128'(3));
      end
      if (wq.size() == 4) check("t1_back_to_back", 128'(wq[3].cyc - wq[0].cyc), 128'(3));
      check("t1_busy_cycles", 128'(busy_cyc),     128'(6));
      check("t1_tile_done3",  128'(tile_done[3]), 128'(1));
      check("t1_done_only3",  128'(tile_done),    128'(1) << 3);
      check("t1_in_ready",    128'(in_ready),     128'(0));
      check("t1_no_err",      128'(err_cnt),      128'(0));

      // 2: gaps in in_valid (1,0,0,1,1,0,1 then held high)
      gap_pat = 16'b1111_1111_1101_1001;
      run_load(7'd7, 32'h100, 32'h200, gap_pat, -1, -1, m_td, m_ad);
      check("t2_nwrites", 128'(wq.size()), 128'(4));
      for (int k = 0; k < 4 && k < wq.size(); k++) begin
         check($sformatf("t2_addr%0d", k),  128'(wq[k].addr),  128'(k));
         check($sformatf("t2_idata%0d", k), 128'(wq[k].idata), 128'(32'h100 + k));
      end
      check("t2_tile_done7",  128'(tile_done[7]), 128'(1));
      check("t2_strobes",     128'(strobe_bad),   128'(0));
      check("t2_write_data",  128'(data_bad),     128'(0));

      // 3a: out-of-range tile select
      wq.delete();
      err_cnt = 0;
      start = 1'b1;
      sel   = 7'd90;
      @(negedge clk);
      start = 1'b0;
      check("t3_err_pulse",  128'(err),  128'(1));
      check("t3_busy_low",   128'(busy), 128'(0));
      @(negedge clk);
      check("t3_err_single", 128'(err),  128'(0));
      start = 1'b1;
      sel   = 7'd127;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("t3_err_count",  128'(err_cnt),   128'(2));
      check("t3_no_writes",  128'(wq.size()), 128'(0));
      check("t3_busy_idle",  128'(busy),      128'(0));

      // 3b: start arriving mid-load is rejected
      run_load(7'd9, 32'h900, 32'hA00, 16'hFFFF, 3, -1, m_td, m_ad);
      check("t3_busy_err", 128'(err_cnt),   128'(1));
      check("t3_nwrites",  128'(wq.size()), 128'(4));
      for (int k = 0; k < 4 && k < wq.size(); k++) begin
         check($sformatf("t3_tile%0d", k), 128'(wq[k].tile), 128'(9));
         check($sformatf("t3_addr%0d", k), 128'(wq[k].addr), 128'(k));
      end
      check("t3_tile_done9",    128'(tile_done[9]), 128'(1));
      check("t3_tile2_untouch", 128'(tile_done[2]), 128'(0));

      // 4: reset after two beats, then a clean reload of the same tile
      run_load(7'd4, 32'h40, 32'h50, 16'hFFFF, -1, 3, m_td, m_ad);
      check("t4_nwrites",   128'(wq.size()), 128'(2));
      check("t4_tile_done", 128'(tile_done), 128'(0));
      check("t4_busy",      128'(busy),      128'(0));
      check("t4_in_ready",  128'(in_ready),  128'(0));
      run_load(7'd4, 32'h40, 32'h50, 16'hFFFF, -1, -1, m_td, m_ad);
      check("t4_re_nwrites", 128'(wq.size()), 128'(4));
      for (int k = 0; k < 4 && k < wq.size(); k++) begin
         check($sformatf("t4_addr%0d", k), 128'(wq[k].addr), 128'(k));
      end
      check("t4_tile_done4", 128'(tile_done[4]), 128'(1));

      // 5: boot every tile, then reload tile 5
      for (int t = 0; t < NT; t++) begin
         run_load(SW'(t), 32'(t) << 8, (32'(t) << 8) | 32'h80, 16'hFFFF, -1, -1, m_td, m_ad);
         check($sformatf("t5_done%0d", t), 128'(tile_done[t]), 128'(1));
         if (t == NT - 2) check("t5_all_done_early", 128'(all_done), 128'(0));
      end
      check("t5_all_tiles",     128'(tile_done), {38'd0, {NT{1'b1}}});
      check("t5_all_done_lag",  128'(all_done),  128'(0));
      @(negedge clk);
      check("t5_all_done_rise", 128'(all_done),  128'(1));
      run_load(7'd5, 32'h55, 32'h66, 16'hFFFF, -1, -1, m_td, m_ad);
      check("t5_reload_td5",   128'(m_td[5]),      128'(0));
      check("t5_reload_ad",    128'(m_ad),         128'(0));
      check("t5_reload_done5", 128'(tile_done[5]), 128'(1));
      @(negedge clk);
      check("t5_all_done_back", 128'(all_done), 128'(1));

`ifdef BOOT_CHECKSUM_EN
      // 6: idata 1..4 + ddata 3..6 = 28
      exp_sum = 32'd28;
      run_load(7'd11, 32'd1, 32'd3, 16'hFFFF, -1, -1, m_td, m_ad);
      check("t6_checksum",   128'(checksum),      128'(28));
      check("t6_good_done",  128'(tile_done[11]), 128'(1));
      check("t6_good_noerr", 128'(err_cnt),       128'(0));
      exp_sum = 32'd29;
      run_load(7'd11, 32'd1, 32'd3, 16'hFFFF, -1, -1, m_td, m_ad);
      check("t6_bad_err",    128'(err_cnt),       128'(1));
      check("t6_bad_done",   128'(tile_done[11]), 128'(0));
      check("t6_sum_holds",  128'(checksum),      128'(28));
`endif

      check("final_strobes",    128'(strobe_bad), 128'(0));
      check("final_write_data", 128'(data_bad),   128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/boot_stream_loader.md
Name: boot_stream_loader

Overview:
- Receiving end of the tile boot stream: accepts paired instruction/data words from an off-chip or test-bench streamer and writes them into the selected tile's instruction and data memories.
- Sits inside the multiprocessor system, between the external boot port and the per-tile imem/dmem write ports.
- Tracks which tiles are fully booted so each tile is released from reset only after its image is complete.

Parameters:
- NUM_TILES, 90, number of processor tiles.
- SEL_WIDTH, 7, width of the tile select (ceil(log2(NUM_TILES))).
- ADDR_WIDTH, 14, word address width of each tile memory.
- DATA_WIDTH, 32, memory word width.
- WORDS, 16384, words per image; the instruction and data images have equal length; 1 <= WORDS <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begin loading tile sel
- sel  in  SEL_WIDTH  tile to load, sampled on start
- in_valid  in  1  stream beat valid
- in_ready  out  1  loader accepts a beat this cycle
- in_idata  in  DATA_WIDTH  instruction word
- in_ddata  in  DATA_WIDTH  data word
- wr_tile  out  SEL_WIDTH  tile addressed by the current write
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_WIDTH  instruction write address
- imem_wdata  out  DATA_WIDTH  instruction write data
- dmem_we  out  1  data memory write strobe
- dmem_addr  out  ADDR_WIDTH  data write address
- dmem_wdata  out  DATA_WIDTH  data write data
- busy  out  1  load in progress
- tile_done  out  NUM_TILES  per-tile booted flag; drives the tile reset release
- all_done  out  1  all tile_done bits are set
- err  out  1  one-cycle error pulse
- exp_sum  in  DATA_WIDTH  expected checksum (used only with the optional feature)
- checksum  out  DATA_WIDTH  running checksum (used only with the optional feature)

Behaviour:
- Reset (resetn=0 at a clk edge):
  - All outputs are 0, state is IDLE, the address counter is 0, and tile_done is cleared.
  - Reset in any state aborts the load immediately; no further writes are issued.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - in_ready=0, busy=0.
  - start with sel < NUM_TILES: latch sel into wr_tile, clear the counter, clear tile_done[sel], go to LOAD.
  - start with sel >= NUM_TILES: err pulse the next cycle, stay in IDLE.
- LOAD:
  - busy=1, in_ready=1.
  - A beat is accepted when in_valid and in_ready are both 1.
  - The cycle after acceptance: imem_we=dmem_we=1, imem_addr=dmem_addr=counter, imem_wdata=in_idata, dmem_wdata=in_ddata. Write latency is exactly 1 cycle, fully pipelined, one beat per cycle.
  - The counter increments per accepted beat.
  - Accepting beat WORDS-1: in_ready drops to 0 the next cycle and the state goes to FLUSH.
  - Beats presented while in_ready=0 are not consumed and produce no writes.
- FLUSH (1 cycle):
  - The last write issues.
  - tile_done[wr_tile] is set on the same edge the write completes.
  - Return to IDLE; busy falls with the return to IDLE.
- start while busy: ignored, err pulse, the load continues unaffected.
- Gaps in in_valid: no writes issue for those cycles and the counter holds.
- Reloading an already-done tile: its tile_done bit clears at start and sets again at completion.
- Write strobes are low in every cycle without an accepted beat one cycle earlier.
- all_done is registered: high the cycle after the last tile_done bit sets.
- Counter width is ADDR_WIDTH+1, so WORDS = 2^ADDR_WIDTH completes without wrap aliasing. The address outputs take the low ADDR_WIDTH bits.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined:
  - checksum clears on start.
  - It accumulates in_idata + in_ddata modulo 2^DATA_WIDTH for each accepted beat.
  - In FLUSH, if checksum != exp_sum: err pulses and tile_done[wr_tile] stays 0.
  - checksum holds its value until the next start.
- Not defined: checksum is tied to 0, exp_sum is ignored, and no checksum error is possible.

Test Plan:
1. WORDS=4, start sel=3, in_valid held high, idata=0x10..0x13, ddata=0x20..0x23 -> imem_we high for 4 consecutive cycles beginning 1 cycle after the first accept, addr 0..3, wr_tile=3; tile_done[3]=1 after FLUSH; busy high for exactly 6 cycles (4 accepts + 1 pipeline + FLUSH).
2. WORDS=4, in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes, addresses 0,1,2,3 contiguous, no write in gap cycles, no extra write after the 4th.
3. start sel=90 -> err=1 for one cycle, busy stays 0, no writes; start during LOAD -> err pulse, wr_tile unchanged, load completes normally.
4. resetn=0 after 2 of 4 beats -> writes stop the next cycle, tile_done all 0, state IDLE; a subsequent full load of the same tile succeeds with addresses starting at 0.
5. Load tiles 0..89 sequentially with NUM_TILES=90 -> all_done rises one cycle after tile 89 completes; reloading tile 5 drops all_done and tile_done[5] until its reload completes.
6. (BOOT_CHECKSUM_EN) WORDS=2, idata={1,2}, ddata={3,4}, exp_sum=10 -> checksum=10, tile_done set; exp_sum=11 -> err pulse in FLUSH, tile_done bit stays 0.
